inst_fetch_queue: RTL and testbench
===================================

// Module: inst_fetch_queue
// PURPOSE
//   Instruction queue between the fetch stage and the decode stage.
//   - Buffers {pc, inst} pairs from fetch in a small FIFO with valid/ready handshakes on both sides.
//   - Decouples fetch from decode stalls.
//   - flush discards all buffered entries on a taken branch or jump.
//   - Decode sees the nop word 32'h00000000 whenever the queue is empty.
// PARAMETERS
//   DEPTH  4   entry count; power of two, >= 2
//   XLEN   32  width of pc and instruction words
// PORTS
//   clk        in   1             rising-edge clock, the only clock
//   rst        in   1             reset: asynchronous, active-high; clears all state
//   flush      in   1             discard all entries (taken branch/jump), synchronous
//   in_valid   in   1             fetch presents in_pc/in_inst
//   in_ready   out  1             queue accepts a push this cycle
//   in_pc      in   XLEN          pc of the pushed instruction
//   in_inst    in   XLEN          instruction word
//   out_valid  out  1             head entry valid for decode
//   out_ready  in   1             decode consumes head this cycle
//   out_pc     out  XLEN          pc of head entry; 0 when empty
//   out_inst   out  XLEN          head instruction; 32'h00000000 (nop) when empty
//   count      out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
// BEHAVIOUR
//   - Reset (async assert, sync release): wr_ptr = rd_ptr = count = 0.
//     After reset: in_ready = 1, out_valid = 0, out_pc = 0, out_inst = 0.
//     Storage contents are not reset.
//   - push = in_valid & in_ready; pop = out_valid & out_ready; both evaluated at the rising edge.
//   - in_ready = (count != DEPTH); registered-state function only.
//     No combinational path from out_ready to in_ready.
//     A push is refused when full, even if a pop occurs in the same cycle.
//   - out_valid = (count != 0). out_pc/out_inst come from mem[rd_ptr] when valid, otherwise 0 / nop.
//   - Latency: a pushed entry is visible at the output one cycle after the push edge. No bypass when empty.
//   - Push and pop in the same cycle (0 < count < DEPTH): count unchanged, both pointers advance.
//   - Pointers are $clog2(DEPTH) bits and wrap naturally modulo DEPTH. count is the sole full/empty indicator.
//   - Order is strict FIFO. Every pushed entry is popped exactly once unless flushed.
//   - flush = 1 at an edge: wr_ptr = rd_ptr = count = 0. It overrides push and pop in the same cycle:
//     the incoming entry is dropped and the head is not counted as consumed.
//     Next cycle: out_valid = 0, in_ready = 1.
//   - flush while empty: no effect beyond the pointer reset.
//   - rst mid-operation: all entries lost immediately (async). out_valid drops in the same cycle rst rises.
//   - in_pc/in_inst are sampled only on push. Other values on those inputs are ignored.
//   - Handshake rules for neighbours: fetch holds in_valid/in_pc/in_inst stable until in_ready.
//     The queue never drops out_valid without a pop, flush or rst.
// STRUCTURE
//   Shared package (cpu_pkg):
//     - localparam XLEN = 32
//     - localparam NOP_INST = 32'h00000000
//     - typedef struct packed {logic [XLEN-1:0] pc; logic [XLEN-1:0] inst;} fq_entry_t
//   Single module; no sub-module. Contents:
//     - storage array fq_entry_t mem[DEPTH], written only on push, no reset
//     - pointer/count register block on clk/posedge rst
//     - combinational output mux
//   Optional assertions:
//     - count <= DEPTH
//     - no push when !in_ready
//     - out signals stable while out_valid & !out_ready
// TESTING
//   1. rst=1, then release -> count=0, in_ready=1, out_valid=0, out_inst=0 on the first cycle.
//   2. Push pc 0x0/0x4/0x8/0xC with out_ready=0 -> count=4, in_ready=0.
//      A 5th push of pc 0x10 is refused. Pops then return pc 0x0, 0x4, 0x8, 0xC in order.
//   3. Full queue, in_valid=1 and out_ready=1 together -> pop only; count 4->3, pc 0x10 not stored.
//      Next cycle the push is accepted.
//   4. Steady stream: push and pop every cycle from count=2 for 10 cycles -> count stays 2.
//      Pointers wrap; output pc sequence is contiguous in +4 steps.
//   5. count=3, flush=1 with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, out_inst=0.
//      A following push of pc 0x20 appears at the head one cycle later.
//   6. rst pulse asynchronous to clk while count=2 -> out_valid falls before the next edge.
//      After release the queue is empty and in_ready=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch/decode datapath.
// Holds the word width, the nop encoding and the fetch-queue entry type.
package cpu_pkg;

    localparam int unsigned XLEN     = 32;
    localparam logic [31:0] NOP_INST = 32'h00000000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fq_entry_t;

endpackage

// File: rtl/inst_fetch_queue.sv
// Instruction queue between fetch and decode.
// A small FIFO of {pc, inst} entries that decode drains. flush discards every entry.
module inst_fetch_queue
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [XLEN-1:0]          in_pc,
    input  logic [XLEN-1:0]          in_inst,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_pc,
    output logic [XLEN-1:0]          out_inst,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    fq_entry_t       mem [DEPTH];
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic            push;
    logic            pop;

    // Full/empty depend only on count, so out_ready never reaches in_ready.
    assign in_ready  = (count != CntW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= '{pc: in_pc, inst: in_inst};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PtrW'(1);
            if (pop)  rd_ptr <= rd_ptr + PtrW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        out_pc   = '0;
        out_inst = NOP_INST;
        if (out_valid) begin
            out_pc   = mem[rd_ptr].pc;
            out_inst = mem[rd_ptr].inst;
        end
    end

    a_count_bound : assert property (@(posedge clk) disable iff (rst)
        count <= CntW'(DEPTH));

    a_head_stable : assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready && !flush)
            |=> (out_valid && $stable(out_pc) && $stable(out_inst)));

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue: a queue-based reference model predicts pops,
// a negedge monitor compares every decode handshake and the empty-queue output values.
module tb_inst_fetch_queue;
    import cpu_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [2:0]  count;

    int checks   = 0;
    int failures = 0;

    fq_entry_t model_q[$];
    fq_entry_t sb_q[$];

    inst_fetch_queue #(.DEPTH(DEPTH), .XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_inst  (out_inst),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: inputs change just after posedge, so negedge sees the upcoming handshake.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready && !flush) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pop: got pc %h expected no pop at %0t", out_pc, $time);
            end else begin
                fq_entry_t e;
                e = sb_q.pop_front();
                chk("pop_pc", out_pc, e.pc);
                chk("pop_inst", out_inst, e.inst);
            end
        end else if (!out_valid) begin
            chk("empty_pc", out_pc, 32'h0);
            chk("empty_inst", out_inst, NOP_INST);
        end
    end

    // Called just after a posedge: check state, drive one cycle, advance the model.
    task automatic step(input bit iv, input logic [31:0] pc, input bit ordy, input bit fl);
        int n;
        n = model_q.size();
        chk("count", 32'(count), 32'(n));
        chk("in_ready", 32'(in_ready), 32'(n < DEPTH));
        chk("out_valid", 32'(out_valid), 32'(n > 0));
        in_valid  = iv;
        in_pc     = pc;
        in_inst   = pc ^ 32'hA5A5_0F0F;
        out_ready = ordy;
        flush     = fl;
        if (fl) begin
            model_q.delete();
        end else begin
            if (ordy && n > 0) sb_q.push_back(model_q.pop_front());
            if (iv && n < DEPTH) model_q.push_back('{pc: pc, inst: pc ^ 32'hA5A5_0F0F});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] pc;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_inst   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Fill to full, refuse a fifth push, then drain in order.
        step(1, 32'h0, 0, 0);
        step(1, 32'h4, 0, 0);
        step(1, 32'h8, 0, 0);
        step(1, 32'hC, 0, 0);
        step(1, 32'h10, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 32'h0, 1, 0);

        // Full queue with push and pop together: pop only, push accepted next cycle.
        for (int i = 0; i < 4; i++) step(1, 32'h100 + 32'(i) * 4, 0, 0);
        step(1, 32'h10, 1, 0);
        step(1, 32'h10, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 32'h0, 1, 0);

        // Steady stream at count=2 with pointer wrap.
        pc = 32'h200;
        step(1, pc, 0, 0); pc += 4;
        step(1, pc, 0, 0); pc += 4;
        for (int i = 0; i < 10; i++) begin
            step(1, pc, 1, 0);
            pc += 4;
        end
        step(0, 32'h0, 1, 0);
        step(0, 32'h0, 1, 0);

        // Flush at count=3 overrides a simultaneous push and pop.
        step(1, 32'h300, 0, 0);
        step(1, 32'h304, 0, 0);
        step(1, 32'h308, 0, 0);
        step(1, 32'h30C, 1, 1);
        step(1, 32'h20, 0, 0);
        step(0, 32'h0, 1, 0);
        step(0, 32'h0, 0, 1);

        // Asynchronous reset mid-operation.
        step(1, 32'h400, 0, 0);
        step(1, 32'h404, 0, 0);
        in_valid = 1'b0;
        #2;
        chk("pre_rst_valid", 32'(out_valid), 32'h1);
        rst = 1'b1;
        #1;
        chk("rst_async_valid", 32'(out_valid), 32'h0);
        chk("rst_async_count", 32'(count), 32'h0);
        model_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(0, 32'h0, 0, 0);

        // Randomized traffic.
        pc = 32'h1000;
        for (int i = 0; i < 400; i++) begin
            bit iv, ordy, fl;
            iv   = ($urandom_range(3) != 0);
            ordy = ($urandom_range(2) != 0);
            fl   = ($urandom_range(24) == 0);
            step(iv, pc, ordy, fl);
            if (iv) pc = pc + 32'($urandom_range(4, 1)) * 4;
        end

        // Drain and confirm every predicted pop was observed.
        while (model_q.size() > 0) step(0, 32'h0, 1, 0);
        step(0, 32'h0, 0, 0);
        chk("sb_empty", 32'(sb_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
